// File: rtl/parity_encoder_pipe.sv
// parity_encoder_pipe: strobe-checked SECDED Hamming encoder feeding a FIFO write port
// through a 2-entry skid buffer, with one-shot error injection and saturating statistics.
module parity_encoder_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int PARITY_BITS = 6,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ecc_en_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [ADDR_WIDTH-1:0]  wr_addr_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strobe_i,
    input  logic                   inj_arm_i,
    input  logic [1:0]             inj_mode_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [ADDR_WIDTH-1:0]  wr_addr_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic [PARITY_BITS:0]   ecc_o,
    output logic                   strb_err_o,
    output logic [CNT_WIDTH-1:0]   wr_cnt_o,
    output logic [CNT_WIDTH-1:0]   strb_err_cnt_o,
    output logic                   inj_pending_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int W  = ADDR_WIDTH + DATA_WIDTH + PARITY_BITS + 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ARMED = 1'b1;

    // Data bits that feed check bit j: data bit i sits at the (i+1)-th non-power-of-two position.
    function automatic logic [DATA_WIDTH-1:0] chk_mask(input int j);
        int i;
        chk_mask = '0;
        i = 0;
        for (int p = 3; p < 2 ** PARITY_BITS; p++)
            if ((p & (p - 1)) != 0 && i < DATA_WIDTH) begin
                chk_mask[i] = ((p >> j) & 1) == 1;
                i++;
            end
    endfunction

    logic                   state;
    logic [1:0]             inj_mode_q;
    logic                   legal, acc, push, pop;
    logic [DATA_WIDTH-1:0]  data_m, data_x;
    logic [PARITY_BITS-1:0] chk;
    logic [PARITY_BITS:0]   ecc_w;
    logic [1:0]             flip;
    logic [W-1:0]           new_word, out_q, skid_q;
    logic                   out_v, skid_v;

    // Adding the lowest set bit clears a contiguous run entirely; any survivor means a gap.
    assign legal = (((wr_strobe_i + (wr_strobe_i & -wr_strobe_i)) & wr_strobe_i) == '0)
                   && $onehot($countones(wr_strobe_i));

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign data_m[8*b +: 8] = wr_strobe_i[b] ? data_i[8*b +: 8] : 8'h00;
    end

    for (genvar j = 0; j < PARITY_BITS; j++) begin : g_chk
        localparam logic [DATA_WIDTH-1:0] M = chk_mask(j);
        assign chk[j] = ^(data_m & M);
    end

    assign ecc_w    = ecc_en_i ? {(^data_m) ^ (^chk), chk} : '0;
    assign flip     = (state == ARMED) ? {inj_mode_q[1], |inj_mode_q} : 2'b00;
    assign data_x   = data_m ^ {{(DATA_WIDTH-2){1'b0}}, flip};
    assign new_word = {wr_addr_i, data_x, ecc_w};

    assign in_ready_o    = !(out_v && skid_v);
    assign acc           = in_valid_i && in_ready_o;
    assign push          = acc && legal;
    assign pop           = out_v && out_ready_i;
    assign out_valid_o   = out_v;
    assign inj_pending_o = state == ARMED;
    assign {wr_addr_o, data_o, ecc_o} = out_q;

    // The output register is the head entry; skid only fills while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else if (!out_v || pop) begin
            out_v  <= skid_v || push;
            skid_v <= skid_v && push;
            if (skid_v || push) out_q <= skid_v ? skid_q : new_word;
            if (skid_v && push) skid_q <= new_word;
        end else if (push) begin
            skid_v <= 1'b1;
            skid_q <= new_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            inj_mode_q <= 2'b00;
        end else if (state == ARMED) begin
            if (push) state <= IDLE;
        end else if (inj_arm_i && inj_mode_i != 2'b00) begin
            state      <= ARMED;
            inj_mode_q <= inj_mode_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_err_o     <= 1'b0;
            wr_cnt_o       <= '0;
            strb_err_cnt_o <= '0;
        end else begin
            strb_err_o     <= acc && !legal;
            wr_cnt_o       <= wr_cnt_o + CNT_WIDTH'(push && !(&wr_cnt_o));
            strb_err_cnt_o <= strb_err_cnt_o + CNT_WIDTH'(acc && !legal && !(&strb_err_cnt_o));
        end
    end
endmodule

// File: tb/tb_parity_encoder_pipe.sv
// tb_parity_encoder_pipe: directed and randomized checks of parity_encoder_pipe against
// a queue-based reference model of the encoder, skid buffer, injection and counters.
module tb_parity_encoder_pipe;
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [6:0]  ecc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ecc_en = 1'b0, in_valid = 1'b0, inj_arm = 1'b0, out_ready = 1'b1;
    logic [4:0]  wr_addr = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  wr_strobe = '0;
    logic [1:0]  inj_mode = '0;
    logic        in_ready, out_valid, strb_err, inj_pending;
    logic [4:0]  wr_addr_out;
    logic [31:0] data_out;
    logic [6:0]  ecc_out;
    logic [15:0] wr_cnt, strb_err_cnt;

    int n_chk = 0;
    int n_fail = 0;

    exp_t        q[$];
    exp_t        m_w;
    logic        m_serr = 1'b0, m_armed = 1'b0, m_acc, m_lg;
    logic [1:0]  m_mode = '0;
    logic [15:0] m_wr = '0, m_se = '0, wr_before;
    logic [31:0] md;

    parity_encoder_pipe dut (
        .clk(clk), .rst_n(rst_n), .ecc_en_i(ecc_en),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .wr_addr_i(wr_addr), .data_i(data_in), .wr_strobe_i(wr_strobe),
        .inj_arm_i(inj_arm), .inj_mode_i(inj_mode),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .wr_addr_o(wr_addr_out), .data_o(data_out), .ecc_o(ecc_out),
        .strb_err_o(strb_err), .wr_cnt_o(wr_cnt), .strb_err_cnt_o(strb_err_cnt),
        .inj_pending_o(inj_pending)
    );

    initial forever #5 clk = ~clk;

    // Build the whole Hamming codeword, then XOR every position whose index has bit j set.
    function automatic logic [6:0] m_ecc(input logic [31:0] d);
        logic [63:0] cw;
        logic [6:0]  e;
        int          k;
        cw = '0;
        e  = '0;
        k  = 0;
        for (int p = 1; p < 64; p++)
            if ((p & (p - 1)) != 0 && k < 32) begin
                cw[p] = d[k];
                k++;
            end
        for (int j = 0; j < 6; j++)
            for (int p = 1; p < 64; p++)
                if (((p >> j) & 1) == 1) e[j] = e[j] ^ cw[p];
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    function automatic logic m_legal(input logic [3:0] s);
        int lo, hi, n;
        lo = -1;
        hi = -1;
        n  = 0;
        for (int i = 0; i < 4; i++)
            if (s[i]) begin
                if (lo < 0) lo = i;
                hi = i;
                n++;
            end
        return n > 0 && n == hi - lo + 1 && (n & (n - 1)) == 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic e, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic arm, input logic [1:0] m, input logic r);
        in_valid  = v;
        ecc_en    = e;
        wr_addr   = a;
        data_in   = d;
        wr_strobe = s;
        inj_arm   = arm;
        inj_mode  = m;
        out_ready = r;
        @(negedge clk);
    endtask

    // Reference model: acceptance uses pre-edge occupancy, then the head drains, then the new word enters.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_serr  = 1'b0;
            m_wr    = '0;
            m_se    = '0;
            m_armed = 1'b0;
            m_mode  = '0;
        end else begin
            m_acc = in_valid && q.size() < 2;
            m_lg  = m_legal(wr_strobe);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            m_serr = m_acc && !m_lg;
            if (m_serr && m_se != 16'hFFFF) m_se++;
            if (m_acc && m_lg) begin
                for (int b = 0; b < 4; b++) md[8*b +: 8] = wr_strobe[b] ? data_in[8*b +: 8] : 8'h00;
                m_w.addr = wr_addr;
                m_w.ecc  = ecc_en ? m_ecc(md) : 7'h00;
                m_w.data = md ^ (m_armed ? (m_mode == 2'b01 ? 32'd1 : 32'd3) : 32'd0);
                q.push_back(m_w);
                if (m_wr != 16'hFFFF) m_wr++;
            end
            if (m_armed) begin
                if (m_acc && m_lg) m_armed = 1'b0;
            end else if (inj_arm && inj_mode != 2'b00) begin
                m_armed = 1'b1;
                m_mode  = inj_mode;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            if (q.size() > 0) begin
                chk("data_o", data_out, q[0].data);
                chk("ecc_o", ecc_out, q[0].ecc);
                chk("wr_addr_o", wr_addr_out, q[0].addr);
            end
            chk("strb_err", strb_err, m_serr);
            chk("wr_cnt", wr_cnt, m_wr);
            chk("strb_err_cnt", strb_err_cnt, m_se);
            chk("inj_pending", inj_pending, m_armed);
        end
    end

    initial begin
        chk("model ecc 1", m_ecc(32'h1), 7'h43);
        chk("model ecc 2", m_ecc(32'h2), 7'h45);
        chk("model ecc 0", m_ecc(32'h0), 7'h00);
        chk("model strb 0110", m_legal(4'b0110), 1'b1);
        chk("model strb 0101", m_legal(4'b0101), 1'b0);
        chk("model strb 0111", m_legal(4'b0111), 1'b0);
        chk("model strb 0000", m_legal(4'b0000), 1'b0);

        #3;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst data_o", data_out, 32'h0);
        chk("rst ecc_o", ecc_out, 7'h0);
        chk("rst counters", {wr_cnt, strb_err_cnt}, 32'h0);
        chk("rst pending", inj_pending, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", in_ready, 1'b1);

        drive(1, 1, 5'd5, 32'h1, 4'hF, 0, 2'b00, 1);
        chk("w1 valid", out_valid, 1'b1);
        chk("w1 data", data_out, 32'h1);
        chk("w1 ecc", ecc_out, 7'h43);
        chk("w1 addr", wr_addr_out, 5'd5);
        drive(1, 1, 5'd6, 32'h2, 4'hF, 0, 2'b00, 1);
        chk("w2 ecc", ecc_out, 7'h45);
        drive(1, 1, 5'd7, 32'hAABBCCDD, 4'b0110, 0, 2'b00, 1);
        chk("strb 0110 data", data_out, 32'h00BBCC00);
        drive(1, 1, 5'd8, 32'hAABBCCDD, 4'b0101, 0, 2'b00, 1);
        chk("strb 0101 no valid", out_valid, 1'b0);
        chk("strb 0101 pulse", strb_err, 1'b1);
        chk("strb 0101 cnt", strb_err_cnt, 16'd1);
        drive(0, 1, 5'd0, 32'h0, 4'hF, 0, 2'b00, 1);
        chk("strb pulse ends", strb_err, 1'b0);

        drive(1, 1, 5'd1, 32'h11111111, 4'hF, 0, 2'b00, 0);
        chk("bp ready 1", in_ready, 1'b1);
        drive(1, 1, 5'd2, 32'h22222222, 4'hF, 0, 2'b00, 0);
        chk("bp ready 2", in_ready, 1'b0);
        drive(1, 1, 5'd3, 32'h33333333, 4'hF, 0, 2'b00, 0);
        chk("bp hold data", data_out, 32'h11111111);
        drive(1, 1, 5'd3, 32'h33333333, 4'hF, 0, 2'b00, 1);
        chk("bp second", data_out, 32'h22222222);
        drive(1, 1, 5'd3, 32'h33333333, 4'hF, 0, 2'b00, 1);
        chk("bp third", data_out, 32'h33333333);
        drive(1, 1, 5'd4, 32'h44444444, 4'hF, 0, 2'b00, 1);
        chk("bp stream 4", data_out, 32'h44444444);
        drive(1, 1, 5'd5, 32'h55555555, 4'hF, 0, 2'b00, 1);
        chk("bp stream 5", data_out, 32'h55555555);
        drive(0, 1, 5'd0, 32'h0, 4'hF, 0, 2'b00, 1);

        drive(0, 1, 5'd0, 32'h0, 4'hF, 1, 2'b10, 1);
        chk("armed", inj_pending, 1'b1);
        drive(1, 1, 5'd9, 32'h0, 4'hF, 0, 2'b00, 1);
        chk("inj data", data_out, 32'h3);
        chk("inj ecc", ecc_out, 7'h00);
        chk("inj cleared", inj_pending, 1'b0);
        drive(1, 1, 5'd10, 32'h0, 4'hF, 0, 2'b00, 1);
        chk("post inj data", data_out, 32'h0);
        drive(1, 1, 5'd11, 32'h1, 4'hF, 1, 2'b01, 1);
        chk("arm+accept uninjected", data_out, 32'h1);
        chk("arm+accept armed", inj_pending, 1'b1);
        drive(1, 1, 5'd12, 32'h10, 4'hF, 0, 2'b00, 1);
        chk("single inj data", data_out, 32'h11);

        wr_before = m_wr;
        drive(1, 0, 5'd13, 32'hFFFFFFFF, 4'hF, 0, 2'b00, 1);
        chk("ecc off ecc", ecc_out, 7'h0);
        chk("ecc off data", data_out, 32'hFFFFFFFF);
        chk("ecc off wr_cnt", wr_cnt, wr_before + 16'd1);

        for (int n = 0; n < 3000; n++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom), $urandom,
                  $urandom_range(0, 1) != 0 ? 4'hF : 4'($urandom), $urandom_range(0, 15) == 0,
                  2'($urandom_range(0, 2)), $urandom_range(0, 9) < 7);

        drive(0, 1, 5'd0, 32'h0, 4'hF, 0, 2'b00, 1);
        drive(0, 1, 5'd0, 32'h0, 4'hF, 0, 2'b00, 1);
        drive(1, 1, 5'd14, 32'hA5A5A5A5, 4'hF, 0, 2'b00, 0);
        drive(1, 1, 5'd15, 32'h5A5A5A5A, 4'hF, 0, 2'b00, 0);
        chk("two buffered", {out_valid, in_ready}, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", out_valid, 1'b0);
        chk("async rst outs", {wr_addr_out, data_out, ecc_out}, 44'h0);
        chk("async rst cnts", {wr_cnt, strb_err_cnt, strb_err, inj_pending}, 34'h0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            drive(0, 1, 5'd0, 32'h0, 4'hF, 0, 2'b00, 1);
            chk("post rst silent", out_valid, 1'b0);
            chk("post rst wr_cnt", wr_cnt, 16'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
